// File: rtl/modexp_pkg.sv
// Shared types and sizing helpers for the modular-exponentiation sequencer.
// Holds the top-level FSM state enum, the multiplier-port phase enum, the
// default widths and the helpers that derive the multiplier operand width and
// the exponent scan-index width from the module parameters.
package modexp_pkg;

  localparam int NLEN_DEF = 1024;
  localparam int TAG_DEF  = 2;
  localparam int ELEN_DEF = 1024;

  // Multiplier operand width: modulus width plus guard bits plus a sign bit.
  localparam int MMW  = NLEN_DEF + TAG_DEF + 1;
  localparam int IDXW = $clog2(ELEN_DEF);

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    SQ_ARM,
    SQ_ISSUE,
    SQ_WAIT,
    MU_ARM,
    MU_ISSUE,
    MU_WAIT,
    NEXT,
    FIN
  } state_e;

  // Phase of a single multiplier transaction (re-arm, launch, collect).
  typedef enum logic [1:0] {
    P_IDLE,
    P_ARM,
    P_ISSUE,
    P_WAIT
  } mm_phase_e;

  function automatic int mm_width(input int nlen, input int tag);
    return nlen + tag + 1;
  endfunction

  function automatic int idx_width(input int elen);
    return (elen > 1) ? $clog2(elen) : 1;
  endfunction

endpackage

// File: rtl/mm_port_ctrl.sv
// One multiplier transaction: ARM (re-arm pulse), ISSUE (launch pulse with
// operands), WAIT (hold operands until the product is valid).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   op_req           start a transaction (accepted when idle or finishing)
//   op_a, op_b       operands, sampled as the ARM cycle ends
//   op_done, op_res  product valid this cycle / low NLEN bits of the product
//   mm_arm           re-arm request toward the multiplier (ORed at the top)
//   mm_in1, mm_in2   zero-extended operands, held until the next transaction
//   mm_in_ready      one-cycle launch
//   mm_out, mm_out_ready  product and its level-valid flag
module mm_port_ctrl
  import modexp_pkg::*;
#(
  parameter int NLEN = 1024,
  parameter int MW   = NLEN + 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_req,
  input  logic [NLEN-1:0] op_a,
  input  logic [NLEN-1:0] op_b,
  output logic            op_done,
  output logic [NLEN-1:0] op_res,
  output logic            mm_arm,
  output logic [MW-1:0]   mm_in1,
  output logic [MW-1:0]   mm_in2,
  output logic            mm_in_ready,
  input  logic [MW-1:0]   mm_out,
  input  logic            mm_out_ready
);

  mm_phase_e phase, phase_nx;

  always_ff @(posedge clk) begin
    if (reset) phase <= P_IDLE;
    else       phase <= phase_nx;
  end

  always_comb begin
    phase_nx = phase;
    case (phase)
      P_IDLE:  if (op_req) phase_nx = P_ARM;
      P_ARM:   phase_nx = P_ISSUE;
      P_ISSUE: phase_nx = P_WAIT;
      // A level-high product seen in any other phase is stale and ignored.
      P_WAIT:  if (mm_out_ready) phase_nx = op_req ? P_ARM : P_IDLE;
      default: phase_nx = P_IDLE;
    endcase
  end

  // Operands are captured once and then held through ISSUE and WAIT so the
  // multiplier sees stable inputs for its whole latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      mm_in1 <= '0;
      mm_in2 <= '0;
    end else if (phase == P_ARM) begin
      mm_in1 <= MW'(op_a);
      mm_in2 <= MW'(op_b);
    end
  end

  assign mm_arm      = (phase == P_ARM);
  assign mm_in_ready = (phase == P_ISSUE);
  assign op_done     = (phase == P_WAIT) && mm_out_ready;
  // The product is already reduced into [0, N), so the guard bits carry nothing.
  assign op_res      = mm_out[NLEN-1:0];

  logic unused_hi;
  assign unused_hi = ^mm_out[MW-1:NLEN];

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer: result = base^exp mod N.
// Each product goes to an external a*b mod N multiplier through mm_port_ctrl.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             request pulse, honoured only when idle and not busy
//   base, exp, N      operands, latched on accept (N odd, > 0)
//   busy              accept+1 cycle through the done cycle inclusive
//   done              one-cycle completion pulse, result valid with it
//   result            last completed value, held until the next one
//   mm_in1/mm_in2     multiplier operands (zero-extended)
//   mm_N              latched modulus, zero-extended
//   mm_in_ready       multiplier launch pulse
//   mm_reset          multiplier re-arm (high when idle and in ARM phases)
//   mm_out/mm_out_ready  multiplier product, level valid until re-armed
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int NLEN = NLEN_DEF,
  parameter int TAG  = TAG_DEF,
  parameter int ELEN = ELEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NLEN-1:0]   base,
  input  logic [ELEN-1:0]   exp,
  input  logic [NLEN-1:0]   N,
  output logic              busy,
  output logic              done,
  output logic [NLEN-1:0]   result,
  output logic [NLEN+TAG:0] mm_in1,
  output logic [NLEN+TAG:0] mm_in2,
  output logic [NLEN:0]     mm_N,
  output logic              mm_in_ready,
  output logic              mm_reset,
  input  logic [NLEN+TAG:0] mm_out,
  input  logic              mm_out_ready
);

  localparam int MW = mm_width(NLEN, TAG);
  localparam int IW = idx_width(ELEN);

  state_e          state, state_nx;
  logic [NLEN-1:0] base_l, n_l;
  logic [ELEN-1:0] exp_l;
  logic [NLEN-1:0] r_q, r_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic            accept;
  logic            op_req, op_done, mm_arm;
  logic [NLEN-1:0] op_b, op_res;

  // ---------------------------------------------------------------------------
  // Multiplier port
  // ---------------------------------------------------------------------------
  // Square uses R for both operands; multiply pairs R with the latched base.
  assign op_b = (state == MU_ARM) ? base_l : r_q;

  mm_port_ctrl #(
    .NLEN (NLEN),
    .MW   (MW)
  ) u_port (
    .clk          (clk),
    .reset        (reset),
    .op_req       (op_req),
    .op_a         (r_q),
    .op_b         (op_b),
    .op_done      (op_done),
    .op_res       (op_res),
    .mm_arm       (mm_arm),
    .mm_in1       (mm_in1),
    .mm_in2       (mm_in2),
    .mm_in_ready  (mm_in_ready),
    .mm_out       (mm_out),
    .mm_out_ready (mm_out_ready)
  );

  assign mm_reset = (state == IDLE) || mm_arm;
  assign mm_N     = {1'b0, n_l};

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // op_req is raised in the cycle before an ARM state so the port block
  // enters its ARM phase in lockstep with the FSM.
  always_comb begin
    state_nx = state;
    r_nx     = r_q;
    idx_nx   = idx;
    op_req   = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !busy) begin
          accept   = 1'b1;
          r_nx     = NLEN'(1);
          idx_nx   = IW'(ELEN - 1);
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (exp_l == '0) begin
          // x^0 mod 1 is 0, not 1.
          r_nx     = (n_l == NLEN'(1)) ? '0 : NLEN'(1);
          state_nx = FIN;
        end else if (exp_l[idx]) begin
          op_req   = 1'b1;
          state_nx = SQ_ARM;
        end else begin
          // Leading zero: a set bit exists below, so idx cannot wrap here.
          idx_nx = idx - IW'(1);
        end
      end
      SQ_ARM:   state_nx = SQ_ISSUE;
      SQ_ISSUE: state_nx = SQ_WAIT;
      SQ_WAIT: begin
        if (op_done) begin
          r_nx = op_res;
          if (exp_l[idx]) begin
            op_req   = 1'b1;
            state_nx = MU_ARM;
          end else begin
            state_nx = NEXT;
          end
        end
      end
      MU_ARM:   state_nx = MU_ISSUE;
      MU_ISSUE: state_nx = MU_WAIT;
      MU_WAIT: begin
        if (op_done) begin
          r_nx     = op_res;
          state_nx = NEXT;
        end
      end
      NEXT: begin
        if (idx == '0) begin
          state_nx = FIN;
        end else begin
          idx_nx   = idx - IW'(1);
          op_req   = 1'b1;
          state_nx = SQ_ARM;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      r_q  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      // An abort keeps the last completed result; only a reset seen while
      // idle (power-up or a held reset) clears it.
      if (state == IDLE) result <= '0;
    end else begin
      idx  <= idx_nx;
      r_q  <= r_nx;
      done <= (state == FIN);
      if (state == FIN) result <= r_q;
      // busy drops on the edge that ends the done cycle.
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base_l <= base;
      exp_l  <= exp;
      n_l    <= N;
    end
  end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Initiator-side sequencer for the modmult responder. Computes result = base^exp mod N by left-to-right square-and-multiply.
- Each product is issued to an external modmult instance over its in_ready/out_ready handshake. That instance computes plain a*b mod N.
- Sits between the RSA/crypto command layer and the multiplier.
- Owns operand muxing, re-arming of the multiplier and exponent scanning.

Parameters:
- NLEN, 1024, modulus/operand width in bits.
- TAG, 2, extra guard bits on multiplier operands (multiplier operand width NLEN+TAG+1, signed).
- ELEN, 1024, exponent width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- base  in  NLEN  base, unsigned, < 2^NLEN (may be >= N)
- exp  in  ELEN  exponent, unsigned
- N  in  NLEN  modulus, odd, > 0
- busy  out  1  high from the cycle after start is accepted until the cycle done is pulsed, inclusive
- done  out  1  one-cycle completion pulse
- result  out  NLEN  final value; held until the next accepted start
- mm_in1  out  NLEN+TAG+1  multiplier operand A, zero-extended
- mm_in2  out  NLEN+TAG+1  multiplier operand B, zero-extended
- mm_N  out  NLEN+1  modulus to multiplier, zero-extended
- mm_in_ready  out  1  one-cycle operation launch
- mm_reset  out  1  multiplier re-arm
- mm_out  in  NLEN+TAG+1  multiplier product
- mm_out_ready  in  1  product valid; level, stays high until the multiplier is re-armed

Behaviour:
- Reset values: busy=0, done=0, result=0, mm_in_ready=0, mm_reset=1, mm_in1=0, mm_in2=0. FSM enters IDLE and the scan index is cleared.
- Reset mid-operation: abort at the next edge with no done pulse. result keeps its last completed value.
- States:
  - IDLE: mm_reset=1. start=1 latches base, exp and N into internal registers, sets R=1, idx=ELEN-1, busy=1, then goes to SCAN. start while busy is ignored.
  - SCAN: one exponent bit per cycle.
    - exp==0: R = (N==1) ? 0 : 1, go to FIN; no multiplier operations.
    - exp[idx]==0: idx decrements.
    - Otherwise go to SQ_ARM. Leading zeros are skipped.
  - SQ_ARM: mm_reset=1 for exactly one cycle, then SQ_ISSUE.
  - SQ_ISSUE: mm_in1=R, mm_in2=R, mm_in_ready=1 for exactly one cycle, then SQ_WAIT.
  - SQ_WAIT: mm_in_ready=0; operands held stable. On mm_out_ready=1, R <= mm_out[NLEN-1:0].
    - If exp[idx]==1, go to MU_ARM; otherwise go to NEXT.
  - MU_ARM / MU_ISSUE / MU_WAIT: as the SQ states with mm_in1=R, mm_in2=base_latched, then NEXT.
  - NEXT: if idx==0 go to FIN; else idx decrements and go to SQ_ARM. No zero-skipping after the first set bit.
  - FIN: result <= R, done=1 for one cycle, busy=0 at the same edge, then IDLE.
- mm_reset is low in every non-IDLE state except the ARM states.
- mm_N is the latched N throughout the operation.
- Operation count for exp!=0: (msb_index+1) squares + popcount(exp) multiplies. Each operation costs 2 cycles plus the multiplier latency.
- Base of 0 needs no special case: the multiplier returns 0 for a zero operand.
- Width rules:
  - Operands are zero-extended from NLEN so they are always non-negative.
  - mm_out is taken as its low NLEN bits and is always in [0, N).
  - idx is $clog2(ELEN) bits; NEXT checks idx==0 before decrementing, so idx never wraps.
- mm_out_ready arriving in any state other than a WAIT state is ignored.

Decomposition:
- Package modexp_pkg holds:
  - the state enum (IDLE, SCAN, SQ_ARM, SQ_ISSUE, SQ_WAIT, MU_ARM, MU_ISSUE, MU_WAIT, NEXT, FIN);
  - the localparams MMW = NLEN+TAG+1 and IDXW = $clog2(ELEN).
- One natural sub-module: mm_port_ctrl. It implements the ARM/ISSUE/WAIT triplet, taking op_req, opA and opB and returning op_done and op_res. It is reused for both square and multiply.
- Top-level FSM stays in modexp_ctrl.

Test Plan:
Bench configuration: NLEN=8, ELEN=8, real modmult instance attached.
- N=13, base=7, exp=5 -> result=11, done once, exactly 5 mm_in_ready pulses, each preceded by a one-cycle mm_reset pulse.
- N=13, base=20, exp=2 -> result=10 (base >= N); 2 squares + 1 multiply.
- exp=0, N=13 -> result=1, zero mm_in_ready pulses, done 3 cycles after start. Repeat with N=1 -> result=0.
- base=0, exp=3, N=13 -> result=0; busy high throughout; start re-pulsed mid-run is ignored and does not corrupt the result.
- reset asserted during the second WAIT of N=13, base=7, exp=5 -> next edge: busy=0, done never pulses, mm_reset=1, result unchanged. A new start with base=2, exp=8, N=13 then gives result=9.
- Back-to-back: start in the cycle after done with base=3, exp=255, N=251 -> result=pow(3,255) mod 251 matches the bench reference model; no leftover mm_out_ready from the previous run is captured.
